dual_ad7528_attenuator: RTL and testbench

Serially programmed stereo volume and cross-mix stage placed between the CD audio decoder's 16-bit PCM outputs and the system audio outputs. It models two AD7528 dual 8-bit multiplying DACs (four gain registers) loaded by the slave microcontroller over a bit-banged 3-wire interface: data, clock and one active-low chip select per DAC chip. Each output channel is the saturated sum of both inputs scaled by their programmed gains.

---
 rtl/dual_ad7528_attenuator.sv | 101 ++++++++++
 tb/tb_dual_ad7528_attenuator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_ad7528_attenuator.sv
// Stereo volume/cross-mix stage modelling two AD7528 dual DACs loaded over a
// bit-banged 3-wire serial link; each output is the saturated, gain-weighted sum of both inputs.
module dual_ad7528_attenuator (
  input  logic               clk,
  input  logic               reset,
  input  logic               datadac,
  input  logic               clkdac,
  input  logic               csdac1n,
  input  logic               csdac2n,
  input  logic signed [15:0] audio_left_in,
  input  logic signed [15:0] audio_right_in,
  output logic signed [15:0] audio_left_out,
  output logic signed [15:0] audio_right_out
);

  logic        clkdac_q, cs1n_q, cs2n_q;
  logic [8:0]  sr_q, sr_d;
  logic [7:0]  g_ll_q, g_rl_q, g_rr_q, g_lr_q;
  logic [7:0]  g_ll_d, g_rl_d, g_rr_d, g_lr_d;
  logic signed [15:0] out_l_q, out_l_d, out_r_q, out_r_d;

  logic clk_rise, cs1_rise, cs2_rise;
  logic signed [24:0] p_ll, p_rl, p_rr, p_lr;
  logic signed [25:0] sum_l, sum_r;

  function automatic logic signed [15:0] sat16(input logic signed [25:0] s);
    logic signed [17:0] r;
    r = s[25:8];
    if (r > $signed(18'h07FFF))      sat16 = 16'sh7FFF;
    else if (r < $signed(18'h38000)) sat16 = 16'sh8000;
    else                             sat16 = r[15:0];
  endfunction

  function automatic logic signed [24:0] scale(input logic signed [15:0] x,
                                               input logic [7:0] g);
    scale = $signed({{9{x[15]}}, x}) * $signed({17'd0, g});
  endfunction

  assign clk_rise = clkdac  & ~clkdac_q;
  assign cs1_rise = csdac1n & ~cs1n_q;
  assign cs2_rise = csdac2n & ~cs2n_q;

  // Latches read sr_q, so a coincident shift never leaks into the latched word.
  always_comb begin
    sr_d   = sr_q;
    g_ll_d = g_ll_q;
    g_rl_d = g_rl_q;
    g_rr_d = g_rr_q;
    g_lr_d = g_lr_q;
    if (clk_rise && (!csdac1n || !csdac2n)) sr_d = {sr_q[7:0], datadac};
    if (cs1_rise) begin
      if (sr_q[8]) g_rl_d = sr_q[7:0];
      else         g_ll_d = sr_q[7:0];
    end
    if (cs2_rise) begin
      if (sr_q[8]) g_lr_d = sr_q[7:0];
      else         g_rr_d = sr_q[7:0];
    end
  end

  always_comb begin
    p_ll    = scale(audio_left_in,  g_ll_q);
    p_rl    = scale(audio_right_in, g_rl_q);
    p_rr    = scale(audio_right_in, g_rr_q);
    p_lr    = scale(audio_left_in,  g_lr_q);
    sum_l   = {p_ll[24], p_ll} + {p_rl[24], p_rl};
    sum_r   = {p_rr[24], p_rr} + {p_lr[24], p_lr};
    out_l_d = sat16(sum_l);
    out_r_d = sat16(sum_r);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkdac_q <= 1'b0;
      cs1n_q   <= 1'b1;
      cs2n_q   <= 1'b1;
      sr_q     <= 9'd0;
      g_ll_q   <= 8'hFF;
      g_rl_q   <= 8'h00;
      g_rr_q   <= 8'hFF;
      g_lr_q   <= 8'h00;
      out_l_q  <= 16'sd0;
      out_r_q  <= 16'sd0;
    end else begin
      clkdac_q <= clkdac;
      cs1n_q   <= csdac1n;
      cs2n_q   <= csdac2n;
      sr_q     <= sr_d;
      g_ll_q   <= g_ll_d;
      g_rl_q   <= g_rl_d;
      g_rr_q   <= g_rr_d;
      g_lr_q   <= g_lr_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
    end
  end

  assign audio_left_out  = out_l_q;
  assign audio_right_out = out_r_q;

endmodule

// File: tb/tb_dual_ad7528_attenuator.sv
// Directed plus randomized checks of the dual AD7528 attenuator against an
// arithmetic model of gains, serial word shifting and saturating mix.
module tb_dual_ad7528_attenuator;

  logic clk = 1'b0;
  logic reset, datadac, clkdac, csdac1n, csdac2n;
  logic signed [15:0] in_l, in_r, out_l, out_r;

  int checks = 0;
  int errors = 0;

  int m_sr;
  int g_ll, g_rl, g_rr, g_lr;

  dual_ad7528_attenuator dut (
    .clk(clk), .reset(reset), .datadac(datadac), .clkdac(clkdac),
    .csdac1n(csdac1n), .csdac2n(csdac2n),
    .audio_left_in(in_l), .audio_right_in(in_r),
    .audio_left_out(out_l), .audio_right_out(out_r)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] mix(input logic signed [15:0] a, input logic signed [15:0] b,
                                      input int ga, input int gb);
    longint s;
    s = longint'(a) * ga + longint'(b) * gb;
    s = s >>> 8;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_l"}, out_l, mix(in_l, in_r, g_ll, g_rl));
    chk({tag, "_r"}, out_r, mix(in_r, in_l, g_rr, g_lr));
  endtask

  task automatic model_reset();
    m_sr = 0;
    g_ll = 255; g_rl = 0; g_rr = 255; g_lr = 0;
  endtask

  task automatic latch1();
    if ((m_sr >> 8) & 1) g_rl = m_sr & 255; else g_ll = m_sr & 255;
  endtask

  task automatic latch2();
    if ((m_sr >> 8) & 1) g_lr = m_sr & 255; else g_rr = m_sr & 255;
  endtask

  // Pulse n clkdac bits (MSB first) under the chosen selects, then raise the selects.
  task automatic write_word(input bit sel1, input bit sel2, input int n, input int bits);
    int b;
    csdac1n = !sel1;
    csdac2n = !sel2;
    step();
    for (int i = n - 1; i >= 0; i--) begin
      b = (bits >> i) & 1;
      datadac = b[0];
      clkdac = 1'b1;
      step();
      if (sel1 || sel2) m_sr = ((m_sr << 1) | b) & 511;
      clkdac = 1'b0;
      step();
    end
    csdac1n = 1'b1;
    csdac2n = 1'b1;
    step();
    check_out("pre_latch");
    if (sel1) latch1();
    if (sel2) latch2();
  endtask

  function automatic logic [15:0] pick_sample();
    case ($urandom_range(0, 3))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b0; datadac = 1'b0; clkdac = 1'b0;
    csdac1n = 1'b1; csdac2n = 1'b1;
    in_l = 16'h4000; in_r = 16'h2000;
    model_reset();
    repeat (3) step();
    chk("reset_l", out_l, 16'h0000);
    chk("reset_r", out_r, 16'h0000);

    reset = 1'b1;
    step();
    step();
    chk("default_l", out_l, 16'h3FC0);
    chk("default_r", out_r, 16'h1FE0);
    check_out("default");

    write_word(1, 0, 9, 9'h000);
    in_l = 16'sd1000; in_r = 16'sd0;
    step();
    check_out("mute");
    chk("mute_const_l", out_l, 16'h0000);

    write_word(1, 0, 9, 9'h0FF);
    in_l = 16'sd0; in_r = 16'h1000;
    step();
    write_word(1, 0, 9, 9'h180);
    chk("xmix_old_gain", out_l, 16'h0000);
    step();
    chk("xmix_new_gain", out_l, 16'h0800);
    check_out("xmix");

    write_word(1, 0, 9, 9'h1FF);
    in_l = 16'sd32767; in_r = 16'sd32767;
    step();
    chk("sat_pos", out_l, 16'h7FFF);
    check_out("sat_pos");
    in_l = -16'sd32768; in_r = -16'sd32768;
    step();
    chk("sat_neg", out_l, 16'h8000);
    check_out("sat_neg");

    write_word(0, 0, 9, 9'h1FF);
    write_word(0, 1, 0, 0);
    in_l = 16'sd12345; in_r = -16'sd2222;
    step();
    check_out("ignore_desel");

    write_word(1, 1, 9, 9'h0A5);
    in_l = 16'h5A5A; in_r = 16'h8123;
    step();
    check_out("both_cs");

    // cs1 rise coincides with a clkdac rise while cs2 still selects.
    csdac1n = 1'b0; csdac2n = 1'b0;
    step();
    for (int i = 8; i >= 0; i--) begin
      datadac = ((9'h13C >> i) & 1) != 0;
      clkdac = 1'b1; step();
      m_sr = ((m_sr << 1) | ((9'h13C >> i) & 1)) & 511;
      clkdac = 1'b0; step();
    end
    datadac = 1'b1; clkdac = 1'b1; csdac1n = 1'b1;
    step();
    check_out("coinc_pre");
    latch1();
    m_sr = ((m_sr << 1) | 1) & 511;
    clkdac = 1'b0; csdac2n = 1'b1;
    step();
    check_out("coinc_mid");
    latch2();
    in_l = 16'h2000; in_r = 16'h3000;
    step();
    check_out("coinc_post");

    for (int it = 0; it < 40; it++) begin
      int sel, n;
      sel = $urandom_range(0, 3);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 9;
      write_word(sel == 0 || sel == 2, sel == 1 || sel == 2, n, int'($urandom & 32'hFFF));
      in_l = pick_sample();
      in_r = pick_sample();
      step();
      check_out("rand");
    end

    csdac1n = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      datadac = 1'b1;
      clkdac = 1'b1; step();
      clkdac = 1'b0; step();
    end
    reset = 1'b0;
    #1;
    chk("async_rst_l", out_l, 16'h0000);
    chk("async_rst_r", out_r, 16'h0000);
    model_reset();
    csdac1n = 1'b1;
    step();
    reset = 1'b1;
    in_l = 16'h4000; in_r = 16'h2000;
    step();
    step();
    check_out("post_rst_default");
    write_word(1, 0, 0, 0);
    step();
    check_out("post_rst_sr_zero");
    chk("post_rst_mute_l", out_l, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
